// File: rtl/mem_resp.sv
// mem_resp: memory-side responder for the core's data-memory load/store path.
// Accepts one request at a time, waits LATENCY cycles, then commits the access
// against a word-addressed backing store and presents the response until it is
// taken. Byte-lane selection, sign/zero extension and byte-merge on stores
// happen here.
// Optional feature: define MEM_RESP_ALIGN_CHK_EN to reject misaligned
// half/word accesses. Without it, half/word accesses use the aligned lane
// that contains the address.
// BASE_ADDR is assumed word aligned.
module mem_resp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_ctr;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic [29:0] woff;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        ctr_ok;
  logic        misalign;
  logic        acc_err;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;
  assign commit    = (state == WAIT) && (cnt == 4'd0);

  // Word offset from the base; anything below the base wraps to a large value
  // and therefore fails the range test as well.
  assign woff     = lat_addr[31:2] - BASE_ADDR[31:2];
  assign idx      = woff[AW-1:0];
  assign in_range = (woff[29:AW] == '0);
  assign ctr_ok   = (lat_ctr == 3'b000) || (lat_ctr == 3'b001) || (lat_ctr == 3'b010) ||
                    (lat_ctr == 3'b100) || (lat_ctr == 3'b101);

`ifdef MEM_RESP_ALIGN_CHK_EN
  assign misalign = ((lat_ctr[1:0] == 2'b01) && lat_addr[0]) ||
                    ((lat_ctr[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = !in_range || !ctr_ok || misalign;
  assign wr_en   = commit && lat_we && !acc_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = WAIT;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load path: lane selection and extension of the addressed word.
  always_comb begin
    rd_word = mem[idx];
    case (lat_addr[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (lat_ctr)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = '0;
    endcase
    if (acc_err || lat_we) load_val = '0;
  end

  // Store path: byte enables and lane-replicated write data (ctr[2] ignored).
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = lat_wd;
    case (lat_ctr[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lat_addr[1:0];
        wr_data = {4{lat_wd[7:0]}};
      end
      2'b01: begin
        wr_be   = lat_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{lat_wd[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Request capture, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_ctr  <= 3'b000;
      lat_addr <= '0;
      lat_wd   <= '0;
      rsp_rd   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        lat_we   <= req_we;
        lat_ctr  <= req_ctr;
        lat_addr <= req_addr;
        lat_wd   <= req_wd;
        cnt      <= 4'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_rd  <= load_val;
        rsp_err <= acc_err;
      end
    end
  end

  // Backing store write (not reset); commit only happens out of WAIT, so an
  // asynchronous reset during WAIT discards the pending store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule
